timer_sched: RTL and testbench

TIMER_SCHED -- requirements
Module: timer_sched

---
 rtl/timer_sched.sv | 105 ++++++++++
 tb/tb_timer_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/timer_sched.sv
// Shared up-counter timer granted round-robin to one of four requesters.
// The owner counts from 0 to its latched duration, then receives a one-cycle done pulse.
module timer_sched #(
    parameter int unsigned N    = 4,
    parameter int unsigned NREQ = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*N-1:0]   dur,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic [NREQ-1:0]     done,
    output logic [N-1:0]        count
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

    state_e        state;
    logic [N-1:0]  target;
    logic [IW-1:0] owner;
    logic [IW-1:0] last_owner;
    logic [IW-1:0] winner;
    logic          any_req;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Scan from farthest to nearest so the index right after last_owner wins;
    // k == NREQ wraps back to last_owner itself, giving it the lowest rank.
    always_comb begin
        winner  = last_owner;
        any_req = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[last_owner + IW'(k)]) begin
                winner  = last_owner + IW'(k);
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            grant      <= '0;
            busy       <= 1'b0;
            done       <= '0;
            count      <= '0;
            target     <= '0;
            owner      <= '0;
            last_owner <= IW'(NREQ - 1);
        end else begin
            unique case (state)
                StIdle: begin
                    done  <= '0;
                    count <= '0;
                    if (any_req) begin
                        state  <= StCount;
                        owner  <= winner;
                        grant  <= onehot(winner);
                        busy   <= 1'b1;
                        target <= dur[winner*N +: N];
                    end
                end
                StCount: begin
                    // Abandon wins over reaching the target in the same cycle.
                    if (!req[owner]) begin
                        state      <= StIdle;
                        grant      <= '0;
                        busy       <= 1'b0;
                        count      <= '0;
                        last_owner <= owner;
                    end else if (count == target) begin
                        state <= StDone;
                        grant <= '0;
                        busy  <= 1'b0;
                        done  <= onehot(owner);
                        count <= '0;
                    end else begin
                        count <= count + N'(1);
                    end
                end
                StDone: begin
                    state      <= StIdle;
                    done       <= '0;
                    last_owner <= owner;
                end
                default: begin
                    state <= StIdle;
                    grant <= '0;
                    busy  <= 1'b0;
                    done  <= '0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: directed literal sequences plus randomized traffic
// checked every cycle against a job-level model.
module tb_timer_sched;
    localparam int N = 4;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic [3:0]     req   = '0;
    logic [4*N-1:0] dur   = '0;
    logic [3:0]     grant;
    logic [3:0]     done;
    logic           busy;
    logic [N-1:0]   count;

    int total = 0;
    int bad   = 0;

    timer_sched #(.N(N), .NREQ(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .dur   (dur),
        .grant (grant),
        .busy  (busy),
        .done  (done),
        .count (count)
    );

    always #5 clk = ~clk;

    // Model: the current job (owner, elapsed cycles, length), a pending done
    // notification, and who was served last.
    int m_owner   = -1;
    int m_elapsed = 0;
    int m_len     = 0;
    int m_done    = -1;
    int m_last    = 3;
    int m_pick;
    bit chk_on    = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_owner = -1; m_elapsed = 0; m_len = 0; m_done = -1; m_last = 3;
        end else if (m_done >= 0) begin
            m_last = m_done;
            m_done = -1;
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (m_elapsed == m_len) begin
                m_done  = m_owner;
                m_owner = -1;
            end else begin
                m_elapsed++;
            end
        end else if (req != 0) begin
            m_pick = -1;
            for (int k = 1; k <= 4; k++)
                if (m_pick < 0 && req[(m_last + k) % 4]) m_pick = (m_last + k) % 4;
            m_owner   = m_pick;
            m_len     = int'(dur[m_pick*N +: N]);
            m_elapsed = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("model grant", int'(grant), (m_owner >= 0) ? (1 << m_owner) : 0);
            check("model busy", int'(busy), (m_owner >= 0) ? 1 : 0);
            check("model done", int'(done), (m_done >= 0) ? (1 << m_done) : 0);
            check("model count", int'(count), (m_owner >= 0) ? m_elapsed : 0);
            check("grant/done overlap", int'((grant != 0) && (done != 0)), 0);
        end
    end

    task automatic expect_cyc(input string name, input int g, input int d, input int c);
        @(negedge clk);
        check({name, " grant"}, int'(grant), g);
        check({name, " busy"}, int'(busy), (g != 0) ? 1 : 0);
        check({name, " done"}, int'(done), d);
        check({name, " count"}, int'(count), c);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        repeat (cycles) expect_cyc("reset", 0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        int lane;
        int g;
        @(posedge clk);
        #1 chk_on = 1'b1;

        // Single requester, duration 3; later dur change must not matter.
        do_reset(2);
        dur = '0; dur[3:0] = 4'd3; req = 4'b0001;
        expect_cyc("r30 c0", 1, 0, 0);
        dur[3:0] = 4'd0;
        expect_cyc("r30 c1", 1, 0, 1);
        expect_cyc("r30 c2", 1, 0, 2);
        expect_cyc("r30 c3", 1, 0, 3);
        expect_cyc("r30 done", 0, 1, 0);
        req = '0;
        expect_cyc("r30 idle", 0, 0, 0);

        // All four requesting, duration 1: strict rotation.
        do_reset(1);
        dur = {4{4'd1}}; req = 4'hF;
        for (int r = 0; r < 5; r++) begin
            g = 1 << (r % 4);
            expect_cyc("r31 c0", g, 0, 0);
            expect_cyc("r31 c1", g, 0, 1);
            expect_cyc("r31 done", 0, g, 0);
            expect_cyc("r31 idle", 0, 0, 0);
        end
        req = '0;

        // Zero duration.
        dur[11:8] = 4'd0; req = 4'b0100;
        expect_cyc("r32 c0", 4, 0, 0);
        expect_cyc("r32 done", 0, 4, 0);
        req = '0;
        expect_cyc("r32 idle", 0, 0, 0);

        // Full-range duration, no wrap.
        dur[7:4] = 4'd15; req = 4'b0010;
        for (int c = 0; c < 16; c++) expect_cyc("r33 cnt", 2, 0, c);
        expect_cyc("r33 done", 0, 2, 0);
        req = '0;
        expect_cyc("r33 idle", 0, 0, 0);

        // Abandon at count 4 hands over to pending requester 1.
        do_reset(1);
        dur[3:0] = 4'd10; dur[7:4] = 4'd0; req = 4'b0011;
        for (int c = 0; c <= 4; c++) expect_cyc("r34 cnt", 1, 0, c);
        req = 4'b0010;
        expect_cyc("r34 abandon", 0, 0, 0);
        expect_cyc("r34 next", 2, 0, 0);
        expect_cyc("r34 done", 0, 2, 0);
        req = '0;
        expect_cyc("r34 idle", 0, 0, 0);

        // Reset mid-count, held for several cycles; requester 0 first afterwards.
        do_reset(1);
        dur[3:0] = 4'd10; req = 4'b0001;
        for (int c = 0; c <= 5; c++) expect_cyc("r35 cnt", 1, 0, c);
        reset = 1'b1;
        repeat (3) expect_cyc("r35 reset", 0, 0, 0);
        reset = 1'b0; req = 4'hF;
        expect_cyc("r35 first", 1, 0, 0);
        req = '0;
        expect_cyc("r35 idle", 0, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            if ($urandom_range(3) == 0) begin
                lane = int'($urandom_range(3));
                dur[lane*N +: N] = ($urandom_range(4) == 0) ? N'($urandom) : N'($urandom_range(3));
            end
            reset = ($urandom_range(150) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
